// File: rtl/riscv_dmi_responder_if.sv
// DMI request/response channel plus the register-bus port of the responder.
// The slave modport is the responder's view; master is the DTM/register-file side.
interface riscv_dmi_responder_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_data_i;
    logic [1:0]            req_op_i;
    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic [DATA_WIDTH-1:0] resp_data_o;
    logic [1:0]            resp_op_o;
    logic                  reg_req_o;
    logic                  reg_we_o;
    logic [ADDR_WIDTH-1:0] reg_addr_o;
    logic [DATA_WIDTH-1:0] reg_wdata_o;
    logic                  reg_ack_i;
    logic                  reg_err_i;
    logic [DATA_WIDTH-1:0] reg_rdata_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_op_i, resp_ready_i,
               reg_ack_i, reg_err_i, reg_rdata_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_op_o,
               reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_op_i, resp_ready_i,
               reg_ack_i, reg_err_i, reg_rdata_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_op_o,
               reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o
    );
endinterface

// File: rtl/riscv_dmi_responder.sv
// DMI target-side responder: one request at a time, single-outstanding register
// bus access with timeout, SUCCESS/FAILED response.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid is held with its payload stable until that edge, and ready/valid
// outputs here depend on state registers only.
module riscv_dmi_responder #(
    parameter int                    ADDR_WIDTH     = 7,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT     = 7'h7F,
    parameter int                    TIMEOUT_CYCLES = 64
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    riscv_dmi_responder_if.slave       bus,
    output logic [1:0]                 state_o
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_WRITE   = 2'd2;
    localparam logic [1:0] OP_RSVD    = 2'd3;
    localparam logic [1:0] RD_SUCCESS = 2'd0;
    localparam logic [1:0] RD_FAILED  = 2'd2;

    // A zero timeout still needs a 1-bit counter to keep the logic legal.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rop_q, rop_d;
    logic                  out_of_range;
    logic                  in_access;

    // Compared one bit wider so a full-range limit is not a constant compare.
    assign out_of_range = {1'b0, bus.req_addr_i} > {1'b0, ADDR_LIMIT};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rop_d   = rop_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_data_i;
                    we_d    = (bus.req_op_i == OP_WRITE);
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (bus.req_op_i == OP_NOP) begin
                        rop_d   = RD_SUCCESS;
                        state_d = S_RESP;
                    end else if (bus.req_op_i == OP_RSVD || out_of_range) begin
                        rop_d   = RD_FAILED;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (bus.reg_ack_i) begin
                    rdata_d = (bus.reg_err_i || we_q) ? '0 : bus.reg_rdata_i;
                    rop_d   = bus.reg_err_i ? RD_FAILED : RD_SUCCESS;
                    state_d = S_RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    rop_d   = RD_FAILED;
                    state_d = S_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rop_q   <= RD_SUCCESS;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rop_q   <= rop_d;
        end
    end

    assign in_access        = (state_q == S_ACCESS);
    assign bus.req_ready_o  = (state_q == S_IDLE);
    assign bus.resp_valid_o = (state_q == S_RESP);
    assign bus.resp_data_o  = rdata_q;
    assign bus.resp_op_o    = rop_q;
    assign bus.reg_req_o    = in_access;
    assign bus.reg_we_o     = in_access & we_q;
    assign bus.reg_addr_o   = in_access ? addr_q : '0;
    assign bus.reg_wdata_o  = in_access ? wdata_q : '0;
    assign state_o          = state_q;
endmodule

// File: tb/tb_riscv_dmi_responder.sv
// Directed bench for riscv_dmi_responder: read, write, error, NOP/reserved,
// out-of-range, timeout, backpressure and mid-access reset.
module tb_riscv_dmi_responder;
    logic       clk_i;
    logic       rstn_i;
    logic [1:0] state;
    int         checks;
    int         errors;

    riscv_dmi_responder_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) bus ();

    riscv_dmi_responder #(
        .ADDR_WIDTH    (7),
        .DATA_WIDTH    (32),
        .ADDR_LIMIT    (7'h40),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus),
        .state_o(state)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        check("req_ready_before_issue", bus.req_ready_o, 1'b1);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_addr_i  = addr;
        bus.req_data_i  = data;
        tick();
        bus.req_valid_i = 1'b0;
        bus.req_op_i    = 2'd0;
        bus.req_addr_i  = 7'h00;
        bus.req_data_i  = 32'h0;
    endtask

    task automatic ack_now(input logic err, input logic [31:0] rdata);
        bus.reg_ack_i   = 1'b1;
        bus.reg_err_i   = err;
        bus.reg_rdata_i = rdata;
        tick();
        bus.reg_ack_i   = 1'b0;
        bus.reg_err_i   = 1'b0;
        bus.reg_rdata_i = 32'h0;
    endtask

    task automatic finish_resp(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_op);
        check({tag, "_resp_valid"}, bus.resp_valid_o, 1'b1);
        check({tag, "_resp_data"}, bus.resp_data_o, exp_data);
        check({tag, "_resp_op"}, bus.resp_op_o, exp_op);
        check({tag, "_ready_in_resp"}, bus.req_ready_o, 1'b0);
        bus.resp_ready_i = 1'b1;
        tick();
        bus.resp_ready_i = 1'b0;
        check({tag, "_ready_after"}, bus.req_ready_o, 1'b1);
        check({tag, "_valid_after"}, bus.resp_valid_o, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, bus.req_ready_o, 1'b1);
        check({tag, "_resp_valid"}, bus.resp_valid_o, 1'b0);
        check({tag, "_resp_data"}, bus.resp_data_o, 32'h0);
        check({tag, "_resp_op"}, bus.resp_op_o, 2'd0);
        check({tag, "_reg_req"}, bus.reg_req_o, 1'b0);
        check({tag, "_reg_we"}, bus.reg_we_o, 1'b0);
        check({tag, "_reg_addr"}, bus.reg_addr_o, 7'h00);
        check({tag, "_reg_wdata"}, bus.reg_wdata_o, 32'h0);
        check({tag, "_state"}, state, 2'd0);
    endtask

    initial begin
        int n;
        logic [31:0] held;
        checks = 0;
        errors = 0;
        rstn_i           = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = 7'h00;
        bus.req_data_i   = 32'h0;
        bus.req_op_i     = 2'd0;
        bus.resp_ready_i = 1'b0;
        bus.reg_ack_i    = 1'b0;
        bus.reg_err_i    = 1'b0;
        bus.reg_rdata_i  = 32'h0;
        #12;
        check_reset_outputs("reset");
        rstn_i = 1'b1;
        tick();

        // Read acked in the second access cycle.
        issue(2'd1, 7'h11, 32'h0);
        check("rd_req_c1", bus.reg_req_o, 1'b1);
        check("rd_we_c1", bus.reg_we_o, 1'b0);
        check("rd_addr_c1", bus.reg_addr_o, 7'h11);
        tick();
        check("rd_req_c2", bus.reg_req_o, 1'b1);
        check("rd_we_c2", bus.reg_we_o, 1'b0);
        ack_now(1'b0, 32'hDEADBEEF);
        check("rd_req_dropped", bus.reg_req_o, 1'b0);
        finish_resp("rd", 32'hDEADBEEF, 2'd0);

        // Write acked in the first access cycle; stray rdata must be ignored.
        issue(2'd2, 7'h10, 32'h80000001);
        check("wr_req", bus.reg_req_o, 1'b1);
        check("wr_we", bus.reg_we_o, 1'b1);
        check("wr_addr", bus.reg_addr_o, 7'h10);
        check("wr_wdata", bus.reg_wdata_o, 32'h80000001);
        check("wr_no_early_valid", bus.resp_valid_o, 1'b0);
        ack_now(1'b0, 32'h12345678);
        check("wr_wdata_quiet", bus.reg_wdata_o, 32'h0);
        finish_resp("wr", 32'h0, 2'd0);

        // Read with bus error.
        issue(2'd1, 7'h05, 32'h0);
        ack_now(1'b1, 32'hCAFEF00D);
        finish_resp("err", 32'h0, 2'd2);

        // NOP, reserved op and out-of-range respond one cycle after acceptance.
        issue(2'd0, 7'h22, 32'h11111111);
        check("nop_no_reg_req", bus.reg_req_o, 1'b0);
        check("nop_addr_quiet", bus.reg_addr_o, 7'h00);
        finish_resp("nop", 32'h0, 2'd0);
        issue(2'd3, 7'h22, 32'h22222222);
        check("rsvd_no_reg_req", bus.reg_req_o, 1'b0);
        finish_resp("rsvd", 32'h0, 2'd2);
        issue(2'd1, 7'h50, 32'h0);
        check("oor_no_reg_req", bus.reg_req_o, 1'b0);
        finish_resp("oor", 32'h0, 2'd2);
        issue(2'd1, 7'h40, 32'h0);
        check("limit_reg_req", bus.reg_req_o, 1'b1);
        ack_now(1'b0, 32'h00000040);
        finish_resp("limit", 32'h00000040, 2'd0);

        // Timeout with no ack: reg_req_o high exactly 8 cycles.
        issue(2'd1, 7'h20, 32'h0);
        n = 0;
        while (bus.reg_req_o && n < 50) begin
            n++;
            tick();
        end
        check("to_req_cycles", n, 8);
        finish_resp("to", 32'h0, 2'd2);

        // Ack in the 8th cycle beats the timeout.
        issue(2'd1, 7'h21, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        check("to8_req_still_high", bus.reg_req_o, 1'b1);
        ack_now(1'b0, 32'h0BADCAFE);
        finish_resp("to8", 32'h0BADCAFE, 2'd0);

        // Backpressure: response held for 5 cycles.
        issue(2'd1, 7'h30, 32'h0);
        ack_now(1'b0, 32'h5A5A1234);
        held = bus.resp_data_o;
        check("bp_first_data", held, 32'h5A5A1234);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus.resp_valid_o, 1'b1);
            check("bp_data", bus.resp_data_o, 32'h5A5A1234);
            check("bp_ready", bus.req_ready_o, 1'b0);
            tick();
        end
        finish_resp("bp", 32'h5A5A1234, 2'd0);

        // Reset in the middle of an access.
        issue(2'd2, 7'h12, 32'hA5A5A5A5);
        check("rst_in_access", bus.reg_req_o, 1'b1);
        #2;
        rstn_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rstn_i = 1'b1;
        tick();
        check("post_rst_no_resp", bus.resp_valid_o, 1'b0);
        issue(2'd1, 7'h13, 32'h0);
        check("post_rst_req", bus.reg_req_o, 1'b1);
        ack_now(1'b0, 32'h13579BDF);
        finish_resp("post_rst", 32'h13579BDF, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
